tt_um_jleugeri_ttt_event_fifo: RTL and testbench

//  Output-side stage downstream of tt_um_jleugeri_ttt_main: captures every processor token event
//  (processor_id_out, token_startstop, output_valid) into a small FIFO and drains it over a

---
 rtl/tt_um_jleugeri_ttt_event_fifo_if.sv | 19 +
 rtl/tt_um_jleugeri_ttt_event_fifo.sv | 113 +++++++++++
 tb/tb_tt_um_jleugeri_ttt_event_fifo.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/tt_um_jleugeri_ttt_event_fifo_if.sv
// Event drain interface: head byte with valid/ready handshake.
// The FIFO drives data/valid (master); the consumer drives ready (slave).
interface tt_um_jleugeri_ttt_event_fifo_if;
    logic [7:0] event_data;
    logic       event_valid;
    logic       event_ready;

    modport master (
        output event_data,
        output event_valid,
        input  event_ready
    );

    modport slave (
        input  event_data,
        input  event_valid,
        output event_ready
    );
endinterface

// File: rtl/tt_um_jleugeri_ttt_event_fifo.sv
// Event FIFO: captures processor token events and drains them as bytes.
// Optional timestep markers are enabled by TTT_EVENT_TSTEP_MARKER_EN.
module tt_um_jleugeri_ttt_event_fifo #(
    parameter int NUM_PROCESSORS = 4,
    parameter int DEPTH          = 8,
    localparam int PROC_BITS     = $clog2(NUM_PROCESSORS),
    localparam int AW            = $clog2(DEPTH),
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic                 clock_fast,
    input  logic                 reset,
    input  logic [PROC_BITS-1:0] processor_id_in,
    input  logic [1:0]           token_startstop_in,
    input  logic                 output_valid_in,
    input  logic [1:0]           stage_in,
    tt_um_jleugeri_ttt_event_fifo_if.master events,
    output logic                 overflow,
    input  logic                 overflow_clear,
    output logic [7:0]           drop_count,
    output logic [CW-1:0]        fill_level
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] count;

    logic          pop;
    logic          ev_req;
    logic          ev_acc;
    logic          mk_req;
    logic          mk_acc;
    logic [CW:0]   free;
    logic [1:0]    drops;
    logic [7:0]    ev_word;
    logic [7:0]    mk_word;
    logic [7:0]    dc_base;
    logic [8:0]    dc_sum;

`ifdef TTT_EVENT_TSTEP_MARKER_EN
    logic [1:0] stage_prev;
    logic [3:0] tstep;

    assign mk_req  = (stage_prev == 2'b11) && (stage_in == 2'b00);
    assign mk_word = {tstep, 2'b00, 2'b10};

    // Track previous stage and count completed timesteps
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            stage_prev <= 2'b00;
            tstep      <= 4'd0;
        end else begin
            stage_prev <= stage_in;
            if (mk_req)
                tstep <= tstep + 4'd1;
        end
    end
`else
    logic unused_stage;

    assign unused_stage = ^stage_in;
    assign mk_req       = 1'b0;
    assign mk_word      = 8'h00;
`endif

    assign events.event_valid = (count != '0);
    assign events.event_data  = mem[rptr];
    assign fill_level         = count;

    assign pop     = events.event_valid && events.event_ready;
    assign ev_req  = output_valid_in && (token_startstop_in != 2'b00);
    assign ev_word = {4'(processor_id_in), token_startstop_in, 2'b01};

    // Free slots after this cycle's pop; events claim a slot before markers
    always_comb begin
        free    = (CW+1)'(DEPTH) - {1'b0, count} + (CW+1)'(pop);
        ev_acc  = ev_req && (free != '0);
        mk_acc  = mk_req && (free > (CW+1)'(ev_req));
        drops   = 2'(ev_req && !ev_acc) + 2'(mk_req && !mk_acc);
        dc_base = overflow_clear ? 8'h00 : drop_count;
        dc_sum  = {1'b0, dc_base} + 9'(drops);
    end

    // Storage, pointers, occupancy and overflow bookkeeping
    always_ff @(posedge clock_fast) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= 8'h00;
            wptr       <= '0;
            rptr       <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= 8'h00;
        end else begin
            if (ev_acc)
                mem[wptr] <= ev_word;
            if (mk_acc)
                mem[wptr + AW'(ev_acc)] <= mk_word;
            wptr  <= wptr + AW'(ev_acc) + AW'(mk_acc);
            rptr  <= rptr + AW'(pop);
            count <= count - CW'(pop) + CW'(ev_acc)
                   + CW'(mk_acc);
            if (drops != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= dc_sum[8] ? 8'hFF : dc_sum[7:0];
            end else if (overflow_clear) begin
                overflow   <= 1'b0;
                drop_count <= 8'h00;
            end
        end
    end

endmodule

// File: tb/tb_tt_um_jleugeri_ttt_event_fifo.sv
// Self-checking bench for the event FIFO with a queue-based model.
// Marker checks run when TTT_EVENT_TSTEP_MARKER_EN is defined.
module tb_tt_um_jleugeri_ttt_event_fifo;
    localparam int DEPTH = 8;

    logic       clock_fast = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] processor_id_in = 2'd0;
    logic [1:0] token_startstop_in = 2'd0;
    logic       output_valid_in = 1'b0;
    logic [1:0] stage_in = 2'd0;
    logic       overflow_clear = 1'b0;
    logic       overflow;
    logic [7:0] drop_count;
    logic [3:0] fill_level;

    tt_um_jleugeri_ttt_event_fifo_if events();

    tt_um_jleugeri_ttt_event_fifo dut (
        .clock_fast         (clock_fast),
        .reset              (reset),
        .processor_id_in    (processor_id_in),
        .token_startstop_in (token_startstop_in),
        .output_valid_in    (output_valid_in),
        .stage_in           (stage_in),
        .events             (events),
        .overflow           (overflow),
        .overflow_clear     (overflow_clear),
        .drop_count         (drop_count),
        .fill_level         (fill_level)
    );

    always #5 clock_fast = ~clock_fast;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q[$];
    int         m_dc = 0;
    bit         m_ov = 1'b0;
    int         m_ts = 0;
    logic [1:0] m_prev = 2'd0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_valid"}, 32'(events.event_valid),
            32'(q.size() != 0));
        chk({tag, "_fill"}, 32'(fill_level), 32'(q.size()));
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ov));
        chk({tag, "_drops"}, 32'(drop_count), 32'(m_dc));
        if (q.size() != 0)
            chk({tag, "_data"}, 32'(events.event_data), 32'(q[0]));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        output_valid_in = 1'b0;
        token_startstop_in = 2'd0;
        stage_in = 2'd0;
        overflow_clear = 1'b0;
        events.event_ready = 1'b0;
        @(posedge clock_fast); #1;
        @(posedge clock_fast); #1;
        reset = 1'b0;
        q.delete();
        m_dc = 0;
        m_ov = 1'b0;
        m_ts = 0;
        m_prev = 2'd0;
        chk("rst_data", 32'(events.event_data), 32'h00);
        model_check("rst");
    endtask

    task automatic cycle(input string tag, input logic [1:0] proc,
                         input logic [1:0] ss, input logic ov,
                         input logic [1:0] st, input logic rdy,
                         input logic clr);
        int d;
        processor_id_in = proc;
        token_startstop_in = ss;
        output_valid_in = ov;
        stage_in = st;
        events.event_ready = rdy;
        overflow_clear = clr;
        d = 0;
        if (rdy && q.size() != 0)
            void'(q.pop_front());
        if (ov && ss != 2'b00) begin
            if (q.size() < DEPTH)
                q.push_back({2'b00, proc, ss, 2'b01});
            else
                d++;
        end
`ifdef TTT_EVENT_TSTEP_MARKER_EN
        if (m_prev == 2'b11 && st == 2'b00) begin
            if (q.size() < DEPTH)
                q.push_back({4'(m_ts), 4'b0010});
            else
                d++;
            m_ts = (m_ts + 1) % 16;
        end
`endif
        m_prev = st;
        if (clr) begin
            m_dc = 0;
            m_ov = 1'b0;
        end
        if (d != 0) begin
            m_ov = 1'b1;
            m_dc = (m_dc + d > 255) ? 255 : m_dc + d;
        end
        @(posedge clock_fast); #1;
        model_check(tag);
    endtask

    task automatic push(input string tag, input logic rdy);
        cycle(tag, 2'($urandom), 2'($urandom_range(1, 3)), 1'b1,
              2'd0, rdy, 1'b0);
    endtask

    task automatic idle(input string tag, input logic rdy);
        cycle(tag, 2'd0, 2'd0, 1'b0, 2'd0, rdy, 1'b0);
    endtask

    initial begin
        events.event_ready = 1'b0;
        do_reset();

        cycle("t1_push", 2'd2, 2'b01, 1'b1, 2'd0, 1'b1, 1'b0);
        chk("t1_head", 32'(events.event_data), 32'h25);
        chk("t1_fill1", 32'(fill_level), 32'd1);
        idle("t1_pop", 1'b1);
        chk("t1_empty", 32'(events.event_valid), 32'd0);

        cycle("t1_ign", 2'd1, 2'b00, 1'b1, 2'd0, 1'b0, 1'b0);

        for (int i = 0; i < 9; i++)
            push("t2_fill", 1'b0);
        chk("t2_full", 32'(fill_level), 32'd8);
        chk("t2_ovf", 32'(overflow), 32'd1);
        chk("t2_drops", 32'(drop_count), 32'd1);
        for (int i = 0; i < 8; i++)
            idle("t2_drain", 1'b1);
        chk("t2_empty", 32'(fill_level), 32'd0);

        push("t3_emp_pp", 1'b1);
        for (int i = 0; i < 7; i++)
            push("t3_fill", 1'b0);
        for (int i = 0; i < 4; i++)
            push("t3_pp", 1'b1);
        chk("t3_full", 32'(fill_level), 32'd8);
        chk("t3_nodrop", 32'(drop_count), 32'd1);

        cycle("t4_clr_drop", 2'd3, 2'b10, 1'b1, 2'd0, 1'b0, 1'b1);
        chk("t4_clr_win", 32'(drop_count), 32'd1);
        for (int i = 0; i < 258; i++)
            push("t4_drop", 1'b0);
        chk("t4_sat", 32'(drop_count), 32'd255);
        push("t4_sat2", 1'b0);
        chk("t4_sat_hold", 32'(drop_count), 32'd255);
        cycle("t4_clr", 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
        chk("t4_clr_dc", 32'(drop_count), 32'd0);
        chk("t4_clr_ov", 32'(overflow), 32'd0);

        for (int i = 0; i < 400; i++)
            cycle("rnd", 2'($urandom), 2'($urandom),
                  1'($urandom), 2'($urandom),
                  1'($urandom), ($urandom_range(0, 15) == 0));

        do_reset();
        for (int i = 0; i < 5; i++)
            push("mid_rst", 1'b0);
        do_reset();
        chk("mid_rst_fill", 32'(fill_level), 32'd0);

`ifdef TTT_EVENT_TSTEP_MARKER_EN
        for (int i = 0; i < 3; i++) begin
            cycle("t5_st3", 2'd0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
            cycle("t5_st0", 2'd0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        end
        chk("t5_fill", 32'(fill_level), 32'd3);
        chk("t5_m0", 32'(events.event_data), 32'h02);
        idle("t5_pop0", 1'b1);
        chk("t5_m1", 32'(events.event_data), 32'h12);
        idle("t5_pop1", 1'b1);
        chk("t5_m2", 32'(events.event_data), 32'h22);
        idle("t5_pop2", 1'b1);

        do_reset();
        for (int i = 0; i < 7; i++)
            push("t6_fill", 1'b0);
        cycle("t6_st3", 2'd0, 2'd0, 1'b0, 2'd3, 1'b0, 1'b0);
        cycle("t6_both", 2'd1, 2'b11, 1'b1, 2'd0, 1'b0, 1'b0);
        chk("t6_full", 32'(fill_level), 32'd8);
        chk("t6_drops", 32'(drop_count), 32'd1);
        for (int i = 0; i < 7; i++)
            idle("t6_drain", 1'b1);
        chk("t6_last", 32'(events.event_data), 32'h1D);
        idle("t6_pop", 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
